prf_wb_arbiter: RTL and testbench

Collects result writes from several functional units and serialises them onto the physical register file's single writeback port (wb_en/wb_addr/wb_data). Each source has a small FIFO behind a valid/ready handshake. A round-robin arbiter grants one non-empty FIFO per cycle, and the winning entry is driven to the register file from an output register. The block sits directly upstream of the register file, between the execute units and its write port.

---
 rtl/prf_pkg.sv | 16 +
 rtl/wb_src_fifo.sv | 51 +++++
 rtl/prf_wb_arbiter.sv | 109 ++++++++++
 tb/tb_prf_wb_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/prf_pkg.sv
// Shared physical-register-file types used by the writeback path.
// A writeback request pairs a destination physical register with its result data.
package prf_pkg;

    localparam int NREGS = 128;
    localparam int XLEN  = 32;
    localparam int PW    = $clog2(NREGS);

    typedef logic [PW-1:0] preg_t;

    typedef struct packed {
        preg_t             preg;
        logic [XLEN-1:0]   data;
    } wb_req_t;

endpackage

// File: rtl/wb_src_fifo.sv
// Small in-order FIFO holding pending writeback requests for one functional unit.
// Ready is derived by the parent from the registered count.
module wb_src_fifo
    import prf_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  wb_req_t       push_req_i,
    output wb_req_t       head_o,
    output logic [CW-1:0] count_o
);

    wb_req_t         mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else if (flush_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else begin
            if (push_i) wr_ptr <= wr_ptr + AW'(1);
            if (pop_i)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_i, pop_i})
                2'b10:   count_o <= count_o + CW'(1);
                2'b01:   count_o <= count_o - CW'(1);
                default: count_o <= count_o;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem[wr_ptr] <= push_req_i;
    end

    assign head_o = mem[rd_ptr];

endmodule

// File: rtl/prf_wb_arbiter.sv
// Serialises result writes from NSRC functional units onto the single register-file
// writeback port through per-source FIFOs and a round-robin arbiter.
module prf_wb_arbiter
    import prf_pkg::*;
#(
    parameter  int NSRC  = 4,
    parameter  int DEPTH = 2,
    localparam int PNDW  = $clog2(NSRC * DEPTH + 1),
    localparam int RRW   = $clog2(NSRC),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic [NSRC-1:0]      src_valid_i,
    output logic [NSRC-1:0]      src_ready_o,
    input  logic [NSRC*PW-1:0]   src_preg_i,
    input  logic [NSRC*XLEN-1:0] src_data_i,
    output logic                 wb_en_o,
    output logic [PW-1:0]        wb_addr_o,
    output logic [XLEN-1:0]      wb_data_o,
    output logic [PNDW-1:0]      pending_o
);

    logic [CW-1:0]   count [NSRC];
    wb_req_t         head  [NSRC];
    logic [NSRC-1:0] push;
    logic [NSRC-1:0] pop;
    logic [NSRC-1:0] nonempty;

    logic            grant_valid;
    logic [RRW-1:0]  grant_idx;
    logic [RRW-1:0]  rr_ptr;
    logic [PNDW-1:0] pending_next;
    wb_req_t         head_sel;

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        wb_req_t in_req;

        assign in_req.preg    = src_preg_i[g*PW +: PW];
        assign in_req.data    = src_data_i[g*XLEN +: XLEN];
        assign src_ready_o[g] = (count[g] != CW'(DEPTH));
        assign nonempty[g]    = (count[g] != '0);
        assign push[g]        = src_valid_i[g] & src_ready_o[g] & ~flush_i;
        assign pop[g]         = grant_valid & (grant_idx == RRW'(g)) & ~flush_i;

        wb_src_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .flush_i    (flush_i),
            .push_i     (push[g]),
            .pop_i      (pop[g]),
            .push_req_i (in_req),
            .head_o     (head[g]),
            .count_o    (count[g])
        );
    end

    // Round-robin search: first non-empty source at or after rr_ptr, wrapping.
    always_comb begin
        int idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NSRC; i++) begin
            idx = (int'(rr_ptr) + i) % NSRC;
            if (!grant_valid && nonempty[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = RRW'(idx);
            end
        end
    end

    assign head_sel = head[grant_idx];

    always_comb begin
        pending_next = pending_o;
        for (int s = 0; s < NSRC; s++) begin
            if (push[s]) pending_next = pending_next + PNDW'(1);
        end
        if (grant_valid) pending_next = pending_next - PNDW'(1);
    end

    // Writes to preg 0 are popped like any other entry but never enable the write port.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wb_en_o   <= 1'b0;
            wb_addr_o <= '0;
            wb_data_o <= '0;
            pending_o <= '0;
            rr_ptr    <= '0;
        end else if (flush_i) begin
            wb_en_o   <= 1'b0;
            pending_o <= '0;
            rr_ptr    <= '0;
        end else begin
            pending_o <= pending_next;
            if (grant_valid) begin
                rr_ptr    <= (grant_idx == RRW'(NSRC - 1)) ? '0 : grant_idx + RRW'(1);
                wb_en_o   <= (head_sel.preg != '0);
                wb_addr_o <= head_sel.preg;
                wb_data_o <= head_sel.data;
            end else begin
                wb_en_o   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_prf_wb_arbiter.sv
// Directed self-checking bench for prf_wb_arbiter with hand-computed expectations.
module tb_prf_wb_arbiter;

    localparam int NSRC = 4;
    localparam int PW   = 7;
    localparam int XLEN = 32;

    logic                 clk_i;
    logic                 rst_i;
    logic                 flush_i;
    logic [NSRC-1:0]      src_valid_i;
    logic [NSRC-1:0]      src_ready_o;
    logic [NSRC*PW-1:0]   src_preg_i;
    logic [NSRC*XLEN-1:0] src_data_i;
    logic                 wb_en_o;
    logic [PW-1:0]        wb_addr_o;
    logic [XLEN-1:0]      wb_data_o;
    logic [3:0]           pending_o;

    int assertCount;
    int failCount;

    prf_wb_arbiter #(.NSRC(NSRC), .DEPTH(2)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .src_valid_i (src_valid_i),
        .src_ready_o (src_ready_o),
        .src_preg_i  (src_preg_i),
        .src_data_i  (src_data_i),
        .wb_en_o     (wb_en_o),
        .wb_addr_o   (wb_addr_o),
        .wb_data_o   (wb_data_o),
        .pending_o   (pending_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int s, input logic v, input logic [PW-1:0] preg, input logic [XLEN-1:0] data);
        src_valid_i[s]             = v;
        src_preg_i[s*PW +: PW]     = preg;
        src_data_i[s*XLEN +: XLEN] = data;
    endtask

    task automatic clearAll();
        for (int s = 0; s < NSRC; s++) applyStimulus(s, 1'b0, '0, '0);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkWb(input string tag, input logic en, input logic [PW-1:0] addr, input logic [XLEN-1:0] data);
        checkOutput({tag, "_en"},   64'(wb_en_o),   64'(en));
        checkOutput({tag, "_addr"}, 64'(wb_addr_o), 64'(addr));
        checkOutput({tag, "_data"}, 64'(wb_data_o), 64'(data));
    endtask

    logic [PW-1:0]   bpAddr [7];
    logic [XLEN-1:0] bpData [7];

    initial begin
        assertCount = 0;
        failCount   = 0;
        rst_i       = 1'b0;
        flush_i     = 1'b0;
        src_valid_i = '0;
        src_preg_i  = '0;
        src_data_i  = '0;

        // Reset state
        #1 rst_i = 1'b1;
        #1;
        checkWb("reset", 1'b0, 7'd0, 32'h0);
        checkOutput("reset_pending", 64'(pending_o), 64'd0);
        checkOutput("reset_ready", 64'(src_ready_o), 64'hF);
        step();
        step();
        rst_i = 1'b0;

        // Single source, one-cycle latency
        $display("[TB] single source");
        applyStimulus(0, 1'b1, 7'd5, 32'hDEADBEEF);
        step();
        clearAll();
        checkOutput("single_pending1", 64'(pending_o), 64'd1);
        checkOutput("single_en_early", 64'(wb_en_o), 64'd0);
        step();
        checkWb("single", 1'b1, 7'd5, 32'hDEADBEEF);
        checkOutput("single_pending0", 64'(pending_o), 64'd0);
        step();
        checkWb("single_after", 1'b0, 7'd5, 32'hDEADBEEF);

        // Flush to bring rr_ptr back to 0
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        checkOutput("flush1_pending", 64'(pending_o), 64'd0);

        // Fairness under full contention
        $display("[TB] fairness");
        for (int s = 0; s < NSRC; s++) applyStimulus(s, 1'b1, 7'(10 + s), 32'h100 + s);
        step();
        checkOutput("fair_pending_fill", 64'(pending_o), 64'd4);
        checkOutput("fair_en_fill", 64'(wb_en_o), 64'd0);
        for (int k = 0; k < 6; k++) begin
            step();
            checkWb($sformatf("fair%0d", k), 1'b1, 7'(10 + (k % 4)), 32'h100 + (k % 4));
            checkOutput($sformatf("fair%0d_pending", k), 64'(pending_o), 64'd7);
        end
        clearAll();
        repeat (8) step();
        checkOutput("fair_drain_pending", 64'(pending_o), 64'd0);
        checkOutput("fair_drain_en", 64'(wb_en_o), 64'd0);

        // Backpressure on source 2 while the others saturate
        $display("[TB] backpressure");
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        applyStimulus(0, 1'b1, 7'd20, 32'h200);
        applyStimulus(1, 1'b1, 7'd21, 32'h201);
        applyStimulus(3, 1'b1, 7'd23, 32'h203);
        applyStimulus(2, 1'b1, 7'd30, 32'hA);
        step();
        checkOutput("bp_ready2_e0", 64'(src_ready_o[2]), 64'd1);
        checkOutput("bp_pending_e0", 64'(pending_o), 64'd4);
        applyStimulus(2, 1'b1, 7'd31, 32'hB);
        step();
        checkOutput("bp_ready2_full", 64'(src_ready_o[2]), 64'd0);
        checkWb("bp_e1", 1'b1, 7'd20, 32'h200);
        checkOutput("bp_pending_e1", 64'(pending_o), 64'd7);
        applyStimulus(2, 1'b1, 7'd32, 32'hC);
        step();
        checkOutput("bp_ready2_stall", 64'(src_ready_o[2]), 64'd0);
        checkWb("bp_e2", 1'b1, 7'd21, 32'h201);
        step();
        checkWb("bp_e3", 1'b1, 7'd30, 32'hA);
        checkOutput("bp_ready2_popped", 64'(src_ready_o[2]), 64'd1);
        step();
        checkWb("bp_e4", 1'b1, 7'd23, 32'h203);
        applyStimulus(2, 1'b0, '0, '0);
        bpAddr = '{7'd20, 7'd21, 7'd31, 7'd23, 7'd20, 7'd21, 7'd32};
        bpData = '{32'h200, 32'h201, 32'hB, 32'h203, 32'h200, 32'h201, 32'hC};
        for (int k = 0; k < 7; k++) begin
            step();
            checkWb($sformatf("bp_e%0d", k + 5), 1'b1, bpAddr[k], bpData[k]);
        end
        clearAll();
        repeat (10) step();
        checkOutput("bp_drain_pending", 64'(pending_o), 64'd0);

        // Write to preg 0 is consumed but never enabled
        $display("[TB] preg zero");
        applyStimulus(1, 1'b1, 7'd0, 32'h1234);
        step();
        clearAll();
        checkOutput("p0_pending1", 64'(pending_o), 64'd1);
        step();
        checkWb("p0", 1'b0, 7'd0, 32'h1234);
        checkOutput("p0_pending0", 64'(pending_o), 64'd0);
        step();
        checkOutput("p0_en_after", 64'(wb_en_o), 64'd0);

        // Flush with five entries queued
        $display("[TB] flush");
        applyStimulus(0, 1'b1, 7'd40, 32'h400);
        applyStimulus(1, 1'b1, 7'd41, 32'h401);
        step();
        checkOutput("fl_pending2", 64'(pending_o), 64'd2);
        for (int s = 0; s < NSRC; s++) applyStimulus(s, 1'b1, 7'(40 + s), 32'h400 + s);
        step();
        checkOutput("fl_pending5", 64'(pending_o), 64'd5);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        clearAll();
        checkOutput("fl_pending0", 64'(pending_o), 64'd0);
        checkOutput("fl_en0", 64'(wb_en_o), 64'd0);
        checkOutput("fl_ready", 64'(src_ready_o), 64'hF);
        step();
        checkOutput("fl_stale1", 64'(wb_en_o), 64'd0);
        step();
        checkOutput("fl_stale2", 64'(wb_en_o), 64'd0);
        checkOutput("fl_pending_after", 64'(pending_o), 64'd0);

        // Asynchronous reset mid-cycle
        $display("[TB] async reset");
        applyStimulus(3, 1'b1, 7'd50, 32'h55);
        step();
        clearAll();
        checkOutput("rs_pending1", 64'(pending_o), 64'd1);
        applyStimulus(0, 1'b1, 7'd51, 32'h66);
        applyStimulus(1, 1'b1, 7'd52, 32'h77);
        step();
        clearAll();
        checkWb("rs_pre", 1'b1, 7'd50, 32'h55);
        checkOutput("rs_pending2", 64'(pending_o), 64'd2);
        #3 rst_i = 1'b1;
        #1;
        checkWb("rs_async", 1'b0, 7'd0, 32'h0);
        checkOutput("rs_pending_async", 64'(pending_o), 64'd0);
        checkOutput("rs_ready_async", 64'(src_ready_o), 64'hF);
        step();
        rst_i = 1'b0;
        step();
        step();
        checkOutput("rs_stale_en", 64'(wb_en_o), 64'd0);
        checkOutput("rs_stale_pending", 64'(pending_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
